exec_unit: RTL and testbench
============================

# exec_unit

Multi-cycle execute stage of the TurtleMCU datapath, directly downstream of the register file. It captures the two 16-bit read-port operands and an operation code on a start strobe. It then computes the result in one cycle for arithmetic and logic ops, one cycle per bit for shifts, or 16 cycles for multiply. It presents the result with a one-cycle `done` pulse that the register file uses directly as its write data and write strobe.

## Interface
- `WIDTH`, 16, datapath width. Shift-count and multiply iteration widths derive from it. Only 16 is verified.
- `clk` in 1, the single clock. All state updates on the rising edge.
- `rst_n` in 1, asynchronous active-low reset. Asserts immediately; releases synchronously with `clk`.
- `start` in 1, request to begin an operation. Sampled only in IDLE.
- `op` in 3, operation select. 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
- `opnd_a` in WIDTH, operand A, taken from register-file read port A.
- `opnd_b` in WIDTH, operand B, taken from register-file read port B. For SHL/SHR only `opnd_b[3:0]` (shift count n) is used.
- `busy` out 1, high whenever the unit is not in IDLE.
- `done` out 1, one-cycle pulse marking `result` and the flags valid. Drives the register-file write strobe.
- `result` out WIDTH, registered result. Drives the register-file write data.
- `flag_z`, `flag_n`, `flag_c` out 1 each, registered zero, negative and carry flags.

## Operation
- States: IDLE, RUN, DONE. `busy` = (state != IDLE). `done` = (state == DONE).
- IDLE with `start`=1:
  - Capture `op`, `opnd_a` and `opnd_b` into internal registers.
  - ADD/SUB/AND/OR/XOR, and SHL/SHR with n=0: compute, load `result` and flags, go to DONE.
  - SHL/SHR with n>0: load the iteration counter with n and go to RUN.
  - MUL: clear the accumulator, load the counter with 16 and go to RUN.
- IDLE with `start`=0: hold all outputs.
- RUN:
  - SHL/SHR: shift the captured A by one bit per cycle. SHR is logical (zero fill).
  - MUL: one shift-add step per cycle, unsigned, on a 32-bit product.
  - Decrement the counter each cycle. On the cycle the counter reaches 0, load `result` and flags and go to DONE.
- DONE: go to IDLE unconditionally.
- `start` outside IDLE is ignored. No queuing and no error indication.
- `result` and the flags hold their values from DONE until the next operation completes. They do not change during RUN.
- Arithmetic is modulo 2^16. `result` is always the low 16 bits.
- `flag_z` = (`result` == 0). `flag_n` = `result[15]`.
- `flag_c` by operation:
  - ADD: carry out of bit 15.
  - SUB: borrow, i.e. 1 when A < B unsigned.
  - SHL/SHR: last bit shifted out. 0 when n=0.
  - AND/OR/XOR: 0.
  - MUL: 1 when the product's upper 16 bits are nonzero.
- Reset (including mid-RUN): state goes to IDLE. `busy`, `done`, `result` and all flags go to 0. Counter and captured operands are cleared. The aborted operation produces no `done`.

## Timing
- Let `start` be accepted at edge t, meaning it is sampled high in IDLE at that edge.
- Single-cycle ops and shifts with n=0: `done`=1 in the cycle after edge t (latency 1).
- SHL/SHR with n>0: RUN for n cycles, `done` after edge t+n (latency n+1, maximum 16).
- MUL: RUN for 16 cycles, `done` after edge t+16 (latency 17).
- `busy` rises after edge t and falls after the edge that leaves DONE.
- Earliest next accepted start is at the edge ending the DONE cycle + 1. Back-to-back single-cycle ops therefore issue every 2 cycles.
- `opnd_a`, `opnd_b` and `op` need only be valid at the accepting edge. Register-file writes during RUN do not affect the operation in flight.

## Test plan
- ADD with A=0xFFFF, B=0x0001 -> `done` 1 cycle after accept; `result`=0x0000, Z=1, N=0, C=1.
- SUB with A=0x0003, B=0x0005 -> `result`=0xFFFE, N=1, C=1, Z=0. XOR with A=0xA5A5, B=0xA5A5 -> `result`=0, Z=1, C=0.
- Shifts:
  - SHL with A=0x8001, n=1 -> `done` at latency 2; `result`=0x0002, C=1.
  - SHR with A=0x8000, n=15 -> latency 16; `result`=0x0001, C=0.
  - SHL with n=0 -> latency 1; `result`=A, C=0.
- MUL with A=300, B=200 -> latency 17; `result`=0xEA60, C=0, N=1. MUL with A=0x0100, B=0x0100 -> `result`=0x0000, Z=1, C=1.
- Start MUL, then pulse `start` with ADD during RUN -> ADD ignored; exactly one `done`, carrying the MUL result; `busy` continuous for 17 cycles.
- Assert `rst_n`=0 mid-MUL (5 cycles after accept) -> `busy`, `done`, `result` and flags go to 0 immediately. After release, no `done` appears and a new ADD completes normally.

Source files
------------

// File: rtl/exec_unit.sv
// Multi-cycle execute stage: single-cycle ALU ops, one-bit-per-cycle shifts and a
// 16-step shift-add multiplier, all reporting through a registered result/flags + done pulse.
module exec_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opnd_a,
  input  logic [WIDTH-1:0] opnd_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
                         OP_XOR = 3'd4, OP_SHL = 3'd5, OP_SHR = 3'd6, OP_MUL = 3'd7;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  state_t             state, state_nxt;
  req_t               req_q;
  logic [2*WIDTH-1:0] acc, acc_step;
  logic [CW-1:0]      cnt;
  logic [SW-1:0]      n_in;
  logic               shift_in, run_in;
  logic [WIDTH-1:0]   alu_res, sh_res, res_d;
  logic               alu_c, sh_c, c_d, ld;
  logic [WIDTH:0]     psum;

  assign n_in     = opnd_b[SW-1:0];
  assign shift_in = (op == OP_SHL) || (op == OP_SHR);
  assign run_in   = (op == OP_MUL) || (shift_in && (n_in != '0));
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (op)
      OP_ADD: {alu_c, alu_res} = {1'b0, opnd_a} + {1'b0, opnd_b};
      OP_SUB: {alu_c, alu_res} = {1'b0, opnd_a} - {1'b0, opnd_b};  // bit WIDTH is the borrow
      OP_AND: alu_res = opnd_a & opnd_b;
      OP_OR:  alu_res = opnd_a | opnd_b;
      OP_XOR: alu_res = opnd_a ^ opnd_b;
      default: alu_res = opnd_a;  // zero-count shift passes A through
    endcase
  end

  // One iteration of the running op; b is consumed LSB-first, product enters acc from the top.
  always_comb begin
    sh_res   = (req_q.op == OP_SHL) ? (req_q.a << 1) : (req_q.a >> 1);
    sh_c     = (req_q.op == OP_SHL) ? req_q.a[WIDTH-1] : req_q.a[0];
    psum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (req_q.b[0] ? {1'b0, req_q.a} : '0);
    acc_step = {psum, acc[WIDTH-1:1]};
  end

  always_comb begin
    state_nxt = state;
    ld        = 1'b0;
    res_d     = '0;
    c_d       = 1'b0;
    case (state)
      IDLE: if (start) begin
        if (run_in) state_nxt = RUN;
        else begin
          state_nxt = DONE;
          ld        = 1'b1;
          res_d     = alu_res;
          c_d       = alu_c;
        end
      end
      RUN: if (cnt == CW'(1)) begin
        state_nxt = DONE;
        ld        = 1'b1;
        if (req_q.op == OP_MUL) begin
          res_d = acc_step[WIDTH-1:0];
          c_d   = |acc_step[2*WIDTH-1:WIDTH];
        end else begin
          res_d = sh_res;
          c_d   = sh_c;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      req_q  <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        req_q <= {op, opnd_a, opnd_b};
        acc   <= '0;
        if (op == OP_MUL)  cnt <= CW'(WIDTH);
        else if (shift_in) cnt <= CW'(n_in);
        else               cnt <= '0;
      end else if (state == RUN) begin
        cnt <= cnt - CW'(1);
        if (req_q.op == OP_MUL) begin
          acc     <= acc_step;
          req_q.b <= req_q.b >> 1;
        end else begin
          req_q.a <= sh_res;
        end
      end
      if (ld) begin
        result <= res_d;
        flag_z <= (res_d == '0);
        flag_n <= res_d[WIDTH-1];
        flag_c <= c_d;
      end
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: expectations queued at issue, popped and compared at done.
module tb_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [15:0] opnd_a, opnd_b;
  logic        busy, done, flag_z, flag_n, flag_c;
  logic [15:0] result;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [15:0] res;
    logic        z, n, c;
    int          lat;
  } exp_t;

  exp_t exp_q[$];

  exec_unit #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .opnd_a(opnd_a), .opnd_b(opnd_b),
    .busy(busy), .done(done), .result(result),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour written independently of the iterative hardware.
  function automatic exp_t model(input string tag, input logic [2:0] o,
                                 input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    logic [16:0] s;
    logic [31:0] p;
    int          n;
    n     = int'(b[3:0]);
    e.tag = tag;
    e.lat = 1;
    e.c   = 1'b0;
    case (o)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; e.res = s[15:0]; e.c = s[16]; end
      3'd1: begin e.res = a - b; e.c = (a < b); end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = a ^ b;
      3'd5: begin s = {1'b0, a} << n; e.res = s[15:0]; e.c = s[16]; e.lat = n + 1; end
      3'd6: begin s = {a, 1'b0} >> n; e.res = s[16:1]; e.c = s[0]; e.lat = n + 1; end
      default: begin p = 32'(a) * 32'(b); e.res = p[15:0]; e.c = |p[31:16]; e.lat = 17; end
    endcase
    e.z = (e.res == 16'h0);
    e.n = e.res[15];
    return e;
  endfunction

  task automatic issue(input string tag, input logic [2:0] o,
                       input logic [15:0] a, input logic [15:0] b, input bit push);
    if (push) exp_q.push_back(model(tag, o, a, b));
    @(negedge clk);
    start = 1'b1; op = o; opnd_a = a; opnd_b = b;
    @(negedge clk);
    start = 1'b0; opnd_a = 16'($urandom); opnd_b = 16'($urandom);
  endtask

  // Entered one cycle after the accepting edge.
  task automatic wait_done();
    exp_t e;
    int   lat;
    e   = exp_q.pop_front();
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({e.tag, "_lat"}, 32'(lat), 32'(e.lat));
    check({e.tag, "_res"}, {16'h0, result}, {16'h0, e.res});
    check({e.tag, "_znc"}, {29'h0, flag_z, flag_n, flag_c}, {29'h0, e.z, e.n, e.c});
    @(negedge clk);
    check({e.tag, "_idle"}, {30'h0, busy, done}, 32'h0);
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    issue(tag, o, a, b, 1'b1);
    wait_done();
  endtask

  initial begin
    exp_t e;
    int   bcnt, dcnt;
    rst_n = 1'b0; start = 1'b0; op = 3'd0; opnd_a = 16'h0; opnd_b = 16'h0;
    repeat (2) @(negedge clk);
    check("reset_outs", {11'h0, busy, done, flag_z, flag_n, flag_c, result}, 32'h0);
    rst_n = 1'b1;

    run("add_wrap",  3'd0, 16'hFFFF, 16'h0001);
    run("sub_borrow",3'd1, 16'h0003, 16'h0005);
    run("xor_zero",  3'd4, 16'hA5A5, 16'hA5A5);
    run("and",       3'd2, 16'hF0F0, 16'h3C3C);
    run("or",        3'd3, 16'h8001, 16'h0F00);
    run("shl_1",     3'd5, 16'h8001, 16'h0001);
    run("shr_15",    3'd6, 16'h8000, 16'h000F);
    run("shl_0",     3'd5, 16'h1234, 16'h0010);
    run("shr_2",     3'd6, 16'h00F3, 16'h0002);
    run("mul_300",   3'd7, 16'd300,  16'd200);
    run("mul_ovf",   3'd7, 16'h0100, 16'h0100);
    for (int i = 0; i < 6; i++)
      run($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));

    // Start pulse during a multiply must be ignored.
    issue("mul_ign", 3'd7, 16'h1234, 16'h0056, 1'b1);
    e = exp_q.pop_front();
    bcnt = 0; dcnt = 0;
    for (int i = 1; i <= 17; i++) begin
      if (busy === 1'b1) bcnt++;
      if (done === 1'b1) dcnt++;
      if (i == 2) begin start = 1'b1; op = 3'd0; opnd_a = 16'h0001; opnd_b = 16'h0001; end
      if (i == 3) start = 1'b0;
      if (i < 17) @(negedge clk);
    end
    check("ign_busy17", 32'(bcnt), 32'd17);
    check("ign_done_at17", {31'h0, done}, 32'h1);
    check("ign_res", {16'h0, result}, {16'h0, e.res});
    check("ign_znc", {29'h0, flag_z, flag_n, flag_c}, {29'h0, e.z, e.n, e.c});
    @(negedge clk);
    check("ign_one_done", {30'h0, busy, done}, 32'h0);
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    check("ign_done_cnt", 32'(dcnt), 32'd1);

    // Reset five cycles into a multiply.
    issue("mul_abort", 3'd7, 16'h00FF, 16'h00FF, 1'b0);
    repeat (4) @(negedge clk);
    check("abort_busy_pre", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("abort_outs", {11'h0, busy, done, flag_z, flag_n, flag_c, result}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    check("abort_no_done", {31'h0, busy} | 32'(dcnt), 32'h0);
    run("add_post", 3'd0, 16'h1111, 16'h2222);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
